// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - fetch PC unit: sequential fetch, branch/JAL/JALR redirect, flush and misalignment trap
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        ex_valid,
  input  logic [31:0] ex_instruction,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs1,
  input  logic        branch,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        flush,
  output logic        trap,
  output logic [15:0] taken_count
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [1:0]  state_q;
  logic [31:0] pc_q;
  logic        trap_q;
  logic [15:0] taken_count_q;

  logic [6:0]  opcode;
  logic        is_sb, is_jal, is_jalr;
  logic [31:0] imm_b, imm_j, imm_i;
  logic [31:0] target;
  logic        redirect_req;
  logic        misaligned;

  assign opcode  = ex_instruction[6:0];
  assign is_sb   = (opcode == OP_SB);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);

  assign imm_b = {{20{ex_instruction[31]}}, ex_instruction[7], ex_instruction[30:25],
                  ex_instruction[11:8], 1'b0};
  assign imm_j = {{12{ex_instruction[31]}}, ex_instruction[19:12], ex_instruction[20],
                  ex_instruction[30:21], 1'b0};
  assign imm_i = {{20{ex_instruction[31]}}, ex_instruction[31:20]};

  always_comb begin
    target = ex_pc + imm_b;
    if (is_jal) begin
      target = ex_pc + imm_j;
    end else if (is_jalr) begin
      target = (ex_rs1 + imm_i) & ~32'h1;
    end
  end

  assign redirect_req = ex_valid & ((is_sb & branch) | is_jal | is_jalr);
  assign misaligned   = target[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      trap_q        <= 1'b0;
      taken_count_q <= 16'h0000;
    end else begin
      case (state_q)
        ST_BOOT: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (redirect_req && misaligned) begin
            trap_q  <= 1'b1;
            state_q <= ST_TRAP;
          end else if (redirect_req) begin
            // Redirect wins over stall/imem_ready: the fetched wrong-path word is dropped anyway.
            pc_q    <= target;
            state_q <= ST_FLUSH;
            if (taken_count_q != 16'hFFFF) begin
              taken_count_q <= taken_count_q + 16'd1;
            end
          end else if (imem_ready && !stall) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        ST_FLUSH: state_q <= ST_FETCH;
        ST_TRAP:  state_q <= ST_TRAP;
        default:  state_q <= ST_BOOT;
      endcase
    end
  end

  // Request and flush decode from the registered state only, so EX inputs never reach outputs.
  assign pc          = pc_q;
  assign imem_req    = (state_q == ST_FETCH);
  assign flush       = (state_q == ST_FLUSH);
  assign trap        = trap_q;
  assign taken_count = taken_count_q;

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Fetch-side program-counter unit that consumes the `branch` decision of the execute-stage branch comparator and closes the control-flow loop. It holds the PC, issues sequential fetch requests, and decodes the EX-stage instruction to compute branch/JAL/JALR targets. On a taken control transfer it redirects the PC and flushes wrong-path instructions for one cycle. It traps on misaligned targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  pipeline hold; the PC does not advance.
- `imem_ready`  in  1  instruction memory accepted the request at `pc` this cycle.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `ex_instruction`  in  32  EX-stage instruction word.
- `ex_pc`  in  32  PC of the EX-stage instruction.
- `ex_rs1`  in  32  rs1 operand of the EX-stage instruction (used by JALR).
- `branch`  in  1  taken decision from the branch comparator; 0 for non-SB instructions.
- `pc`  out  32  current fetch address (registered).
- `imem_req`  out  1  fetch request valid.
- `flush`  out  1  kill IF/ID and ID/EX contents (registered).
- `trap`  out  1  misaligned control-transfer target; sticky.
- `taken_count`  out  16  number of accepted redirects; saturates at 16'hFFFF.

## Operation
- The opcode is `ex_instruction[6:0]`:
  - SB = 7'b1100011
  - JAL = 7'b1101111
  - JALR = 7'b1100111
- `redirect_req = ex_valid & ((SB & branch) | JAL | JALR)`. It is evaluated only in FETCH.
- Immediates are sign-extended to 32 bits, per the RV32I B, J and I formats.
- Target computation, all arithmetic modulo 2^32 (wrap-around allowed, no overflow flag):
  - SB: `ex_pc + immB`.
  - JAL: `ex_pc + immJ`.
  - JALR: `(ex_rs1 + immI) & ~32'h1`.
- Misaligned means `target[1] == 1` after bit-0 clearing.
- States:
  - BOOT is the reset state: `imem_req=0`. It always goes to FETCH at the next edge.
  - FETCH: `imem_req=1`. Priority order, highest first:
    1. `redirect_req` with a misaligned target: `trap<=1`, PC unchanged, go to TRAP. `taken_count` does not increment.
    2. `redirect_req` with an aligned target: `pc<=target`, `flush<=1`, `taken_count` increments (saturating), go to FLUSH. This overrides `stall` and `imem_ready`.
    3. `imem_ready & ~stall`: `pc<=pc+4`.
    4. Otherwise `pc` holds.
  - FLUSH: `imem_req=0`, `flush=1`. `ex_valid`, `branch` and `stall` are ignored because EX holds a wrong-path instruction. At the next edge: `flush<=0`, go to FETCH.
  - TRAP: `imem_req=0`, `flush=0`, `trap=1`, PC frozen. Only reset exits this state.
- Reset values (asserted asynchronously): `pc=RESET_PC`, `imem_req=0`, `flush=0`, `trap=0`, `taken_count=0`, state BOOT.
- Reset mid-FLUSH or in TRAP returns the block to BOOT immediately.

## Timing
- Redirect latency: `redirect_req` is sampled at edge N. `pc=target` and `flush=1` are visible after edge N. The first target fetch (`imem_req=1`) occurs in the cycle after edge N+1.
- The redirect penalty is exactly one bubble cycle beyond the wrong-path instructions that are flushed.
- `flush` is high for exactly one cycle per redirect. Back-to-back redirects are impossible because FLUSH masks EX.
- Sequential fetch gives one PC increment per cycle in which `imem_ready=1` and `stall=0`. PC advance requires `imem_req=1` (FETCH only).
- `imem_req` and `flush` are functions of state only. There is no combinational path from `ex_*`/`branch` to any output.

## Test plan
- Reset and sequential fetch: `RESET_PC=0x0`; deassert `rst_n`; hold `imem_ready=1`, `stall=0`.
  - Required: `imem_req=0` for one cycle, then `pc` = 0x0, 0x4, 0x8.
  - Then `stall=1` for 3 cycles: `pc` holds at 0x8.
- Taken beq: `ex_valid=1`, `ex_pc=0x100`, `ex_instruction=0x00208463`, `branch=1`.
  - Required: next cycle `pc=0x108`, `flush=1`, `imem_req=0`, `taken_count=1`.
  - The cycle after: `flush=0`, `imem_req=1`.
- Not-taken beq: same stimulus as above but `branch=0`.
  - Required: no flush, `pc` increments by 4, `taken_count` unchanged.
- Backward JAL with wrap: `ex_pc=0x200`, `ex_instruction=0xFFDFF06F` (JAL x0,-4).
  - Required: `pc=0x1FC`, one-cycle flush.
  - Repeat with `ex_pc=0x0`: `pc=0xFFFF_FFFC`.
- JALR and misalignment:
  - Aligned: `ex_rs1=0x301`, `ex_instruction=0x00308067` (JALR x0,3(x1)). Required: `pc=0x304`.
  - Misaligned: `ex_rs1=0x300`, `ex_instruction=0x00208067` (target 0x302). Required: `trap=1`, `pc` frozen, `imem_req=0` until `rst_n` asserted, `taken_count` unchanged.
- Redirect under stall and saturation:
  - Taken branch while `stall=1`, `imem_ready=0`. Required: redirect still taken.
  - Preload 65535 redirects, then one more. Required: `taken_count` stays 0xFFFF.
